// File: rtl/intr_pkg.sv
// Shared constants for the CLINT-style machine interrupt controller:
// mcause encodings, register word indices and mip bit positions.
package intr_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned WIDX_W = 3;
   localparam int unsigned MIP_W  = 3;
   localparam int unsigned TIME_W = 64;

   localparam logic [XLEN-1:0] CAUSE_MSI = 32'h8000_0003;
   localparam logic [XLEN-1:0] CAUSE_MTI = 32'h8000_0007;
   localparam logic [XLEN-1:0] CAUSE_MEI = 32'h8000_000B;

   localparam logic [WIDX_W-1:0] REG_MSIP        = 3'd0;
   localparam logic [WIDX_W-1:0] REG_MTIMECMP_LO = 3'd1;
   localparam logic [WIDX_W-1:0] REG_MTIMECMP_HI = 3'd2;
   localparam logic [WIDX_W-1:0] REG_MTIME_LO    = 3'd3;
   localparam logic [WIDX_W-1:0] REG_MTIME_HI    = 3'd4;

   localparam int unsigned MIP_MSIP = 0;
   localparam int unsigned MIP_MTIP = 1;
   localparam int unsigned MIP_MEIP = 2;

   // One register-bus access as seen by the decode logic.
   typedef struct packed {
      logic              sel;
      logic              we;
      logic [WIDX_W-1:0] widx;
      logic [XLEN-1:0]   wdata;
   } bus_req_t;

endpackage

// File: rtl/intr_mtimer.sv
// Machine timer: prescaler, 64-bit mtime, mtimecmp and the registered
// mtime >= mtimecmp compare that drives MTIP.
module intr_mtimer
   import intr_pkg::*;
#(
   parameter int unsigned       TICK_DIV     = 1,
   parameter logic [TIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_cmp_lo,
   input  logic              i_wr_cmp_hi,
   input  logic              i_wr_mtime_lo,
   input  logic              i_wr_mtime_hi,
   input  logic [XLEN-1:0]   i_wdata,
   output logic [TIME_W-1:0] o_mtime,
   output logic [TIME_W-1:0] o_mtimecmp,
   output logic              o_mtip
);

   localparam int unsigned       PRE_W   = 16;
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]  r_pre;
   logic [TIME_W-1:0] r_mtime;
   logic [TIME_W-1:0] r_mtimecmp;
   logic              r_mtip;
   logic              w_tick;
   logic              w_mtime_wr;

   assign w_tick     = (r_pre == PRE_MAX);
   assign w_mtime_wr = i_wr_mtime_lo | i_wr_mtime_hi;

   // A software write to either mtime half overrides the tick for that cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pre      <= '0;
         r_mtime    <= '0;
         r_mtimecmp <= MTIMECMP_RST;
         r_mtip     <= 1'b0;
      end else begin
         if (w_mtime_wr || w_tick) begin
            r_pre <= '0;
         end else begin
            r_pre <= r_pre + PRE_W'(1);
         end

         if (i_wr_mtime_lo) begin
            r_mtime[31:0] <= i_wdata;
         end else if (i_wr_mtime_hi) begin
            r_mtime[63:32] <= i_wdata;
         end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
         end

         if (i_wr_cmp_lo) begin
            r_mtimecmp[31:0] <= i_wdata;
         end
         if (i_wr_cmp_hi) begin
            r_mtimecmp[63:32] <= i_wdata;
         end

         r_mtip <= (r_mtime >= r_mtimecmp);
      end
   end

   assign o_mtime    = r_mtime;
   assign o_mtimecmp = r_mtimecmp;
   assign o_mtip     = r_mtip;

endmodule

// File: rtl/interrupt_ctrl.sv
// CLINT-style machine interrupt controller: register decode, external pending
// latch and prioritised request. INTR_EXT_SYNC_EN adds a 2-flop ext_irq synchroniser.
module interrupt_ctrl
   import intr_pkg::*;
#(
   parameter int unsigned       TICK_DIV     = 1,
   parameter logic [TIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_bus_sel,
   input  logic              i_bus_we,
   input  logic [ADDR_W-1:0] i_bus_addr,
   input  logic [XLEN-1:0]   i_bus_wdata,
   output logic [XLEN-1:0]   o_bus_rdata,
   input  logic              i_ext_irq,
   input  logic              i_mie_msie,
   input  logic              i_mie_mtie,
   input  logic              i_mie_meie,
   input  logic              i_trap_ack,
   output logic              o_interrupt_req,
   output logic [XLEN-1:0]   o_interrupt_cause,
   output logic [MIP_W-1:0]  o_mip_bits
);

   bus_req_t          w_req;
   logic              w_wr;
   logic              w_rd;
   logic [XLEN-1:0]   w_rd_mux;
   logic [TIME_W-1:0] w_mtime;
   logic [TIME_W-1:0] w_mtimecmp;
   logic              w_mtip;
   logic              w_ext_s;
   logic              w_ext_rise;
   logic              w_unused_addr;

   logic [XLEN-1:0]   r_rdata;
   logic              r_msip;
   logic              r_ext_prev;
   logic              r_ext_pend;
   logic [XLEN-1:0]   r_cause;

   assign w_req = '{sel: i_bus_sel, we: i_bus_we, widx: i_bus_addr[4:2], wdata: i_bus_wdata};
   assign w_wr  = w_req.sel & w_req.we;
   assign w_rd  = w_req.sel & ~w_req.we;
   assign w_unused_addr = ^i_bus_addr[1:0];

   intr_mtimer #(
      .TICK_DIV     (TICK_DIV),
      .MTIMECMP_RST (MTIMECMP_RST)
   ) u_mtimer (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_wr_cmp_lo   (w_wr && (w_req.widx == REG_MTIMECMP_LO)),
      .i_wr_cmp_hi   (w_wr && (w_req.widx == REG_MTIMECMP_HI)),
      .i_wr_mtime_lo (w_wr && (w_req.widx == REG_MTIME_LO)),
      .i_wr_mtime_hi (w_wr && (w_req.widx == REG_MTIME_HI)),
      .i_wdata       (w_req.wdata),
      .o_mtime       (w_mtime),
      .o_mtimecmp    (w_mtimecmp),
      .o_mtip        (w_mtip)
   );

`ifdef INTR_EXT_SYNC_EN
   logic [1:0] r_ext_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ext_sync <= '0;
      end else begin
         r_ext_sync <= {r_ext_sync[0], i_ext_irq};
      end
   end

   assign w_ext_s = r_ext_sync[1];
`else
   assign w_ext_s = i_ext_irq;
`endif

   assign w_ext_rise = w_ext_s & ~r_ext_prev;

   always_comb begin
      w_rd_mux = '0;
      case (w_req.widx)
         REG_MSIP:        w_rd_mux = {31'd0, r_msip};
         REG_MTIMECMP_LO: w_rd_mux = w_mtimecmp[31:0];
         REG_MTIMECMP_HI: w_rd_mux = w_mtimecmp[63:32];
         REG_MTIME_LO:    w_rd_mux = w_mtime[31:0];
         REG_MTIME_HI:    w_rd_mux = w_mtime[63:32];
         default:         w_rd_mux = '0;
      endcase
   end

   // External > software > timer; cause holds its last value when idle.
   always_comb begin
      o_interrupt_req   = 1'b0;
      o_interrupt_cause = r_cause;
      if (r_ext_pend && i_mie_meie) begin
         o_interrupt_req   = 1'b1;
         o_interrupt_cause = CAUSE_MEI;
      end else if (r_msip && i_mie_msie) begin
         o_interrupt_req   = 1'b1;
         o_interrupt_cause = CAUSE_MSI;
      end else if (w_mtip && i_mie_mtie) begin
         o_interrupt_req   = 1'b1;
         o_interrupt_cause = CAUSE_MTI;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata    <= '0;
         r_msip     <= 1'b0;
         r_ext_prev <= 1'b0;
         r_ext_pend <= 1'b0;
         r_cause    <= '0;
      end else begin
         if (w_rd) begin
            r_rdata <= w_rd_mux;
         end
         if (w_wr && (w_req.widx == REG_MSIP)) begin
            r_msip <= w_req.wdata[0];
         end
         r_ext_prev <= w_ext_s;
         // A new edge beats a same-cycle acknowledge so no request is lost.
         if (w_ext_rise) begin
            r_ext_pend <= 1'b1;
         end else if (i_trap_ack && (o_interrupt_cause == CAUSE_MEI)) begin
            r_ext_pend <= 1'b0;
         end
         r_cause <= o_interrupt_cause;
      end
   end

   assign o_bus_rdata = r_rdata;

   always_comb begin
      o_mip_bits           = '0;
      o_mip_bits[MIP_MSIP] = r_msip;
      o_mip_bits[MIP_MTIP] = w_mtip;
      o_mip_bits[MIP_MEIP] = r_ext_pend;
   end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed self-checking bench for interrupt_ctrl; one instance with TICK_DIV=4
// and one with TICK_DIV=1 share the same stimulus.
module tb_interrupt_ctrl;

`ifdef INTR_EXT_SYNC_EN
   localparam int EXT_LAT = 3;
`else
   localparam int EXT_LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        ext;
   logic        msie;
   logic        mtie;
   logic        meie;
   logic        ack;

   logic [31:0] rdata4, cause4, rdata1, cause1;
   logic        req4, req1;
   logic [2:0]  mip4, mip1;
   logic [31:0] d4, d1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   interrupt_ctrl #(.TICK_DIV(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_bus_sel(sel), .i_bus_we(we), .i_bus_addr(addr),
      .i_bus_wdata(wdata), .o_bus_rdata(rdata4), .i_ext_irq(ext), .i_mie_msie(msie),
      .i_mie_mtie(mtie), .i_mie_meie(meie), .i_trap_ack(ack), .o_interrupt_req(req4),
      .o_interrupt_cause(cause4), .o_mip_bits(mip4)
   );

   interrupt_ctrl #(.TICK_DIV(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_bus_sel(sel), .i_bus_we(we), .i_bus_addr(addr),
      .i_bus_wdata(wdata), .o_bus_rdata(rdata1), .i_ext_irq(ext), .i_mie_msie(msie),
      .i_mie_mtie(mtie), .i_mie_meie(meie), .i_trap_ack(ack), .o_interrupt_req(req1),
      .o_interrupt_cause(cause1), .o_mip_bits(mip1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Tasks start and end on a negedge; exactly one posedge sees the access.
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a);
      sel = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      sel = 1'b0;
      d4 = rdata4;
      d1 = rdata1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      ext = 1'b0; msie = 1'b1; mtie = 1'b1; meie = 1'b1; ack = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_rdata4", 64'(rdata4), 64'd0);
      check("rst_req4",   64'(req4),   64'd0);
      check("rst_cause4", 64'(cause4), 64'd0);
      check("rst_mip4",   64'(mip4),   64'd0);
      check("rst_rdata1", 64'(rdata1), 64'd0);
      rst = 1'b0;

      bus_read(5'h04);
      check("cmp_lo_rst4", 64'(d4), 64'hFFFF_FFFF);
      check("cmp_lo_rst1", 64'(d1), 64'hFFFF_FFFF);
      bus_read(5'h08);
      check("cmp_hi_rst4", 64'(d4), 64'hFFFF_FFFF);
      check("cmp_hi_rst1", 64'(d1), 64'hFFFF_FFFF);

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle_req", 64'({req4, req1}), 64'd0);
      end

      // Timer: TICK_DIV=4, compare at 10 -> MTIP 41 cycles after mtime write
      bus_write(5'h04, 32'd10);
      bus_write(5'h08, 32'd0);
      bus_write(5'h0C, 32'd0);
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         check("mtip_timing", 64'(mip4[1]), 64'(k == 41));
      end
      check("mtip_req",   64'(req4),   64'd1);
      check("mtip_cause", 64'(cause4), 64'h8000_0007);

      bus_read(5'h07);
      check("addr_lsb_ignored", 64'(d4), 64'd10);
      bus_write(5'h14, 32'hDEAD_BEEF);
      bus_read(5'h15);
      check("word5_reads0", 64'(d4), 64'd0);

      // Software interrupt beats timer
      bus_write(5'h00, 32'hFFFF_FFFF);
      check("msi_req",   64'(req4),   64'd1);
      check("msi_cause", 64'(cause4), 64'h8000_0003);
      check("msi_mip",   64'(mip4),   64'b011);
      bus_read(5'h00);
      check("msip_read", 64'(d4), 64'd1);
      mtie = 1'b0;
      bus_write(5'h00, 32'd0);
      check("msi_drop_req",   64'(req4),   64'd0);
      check("msi_hold_cause", 64'(cause4), 64'h8000_0003);
      check("mip_raw",        64'(mip4),   64'b010);
      mtie = 1'b1;
      bus_write(5'h00, 32'd1);
      check("msi_again", 64'(cause4), 64'h8000_0003);

      // External beats software; trap_ack retires it
      ext = 1'b1;
      for (int k = 1; k <= EXT_LAT; k++) begin
         @(negedge clk);
         check("meip_latency", 64'(mip4[2]), 64'(k == EXT_LAT));
      end
      check("mei_cause", 64'(cause4), 64'h8000_000B);
      check("mei_mip",   64'(mip4),   64'b111);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("ack_mip",   64'(mip4),   64'b011);
      check("ack_cause", 64'(cause4), 64'h8000_0003);

      // Level drop keeps pending; new edge with ack in the same cycle: set wins
      ext = 1'b0;
      repeat (EXT_LAT + 1) @(negedge clk);
      ext = 1'b1;
      repeat (EXT_LAT) @(negedge clk);
      check("mei_reassert", 64'(cause4), 64'h8000_000B);
      ext = 1'b0;
      repeat (EXT_LAT + 1) @(negedge clk);
      check("mei_level_hold", 64'(mip4[2]), 64'd1);
      ext = 1'b1;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      repeat (EXT_LAT - 1) @(negedge clk);
      check("set_wins", 64'(mip4[2]), 64'd1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("ack_clear2", 64'(mip4[2]), 64'd0);
      ext = 1'b0;
      repeat (EXT_LAT + 1) @(negedge clk);

      // mtime wrap with TICK_DIV=1 (u_dut1); u_dut4 checks prescaler restart
      bus_write(5'h10, 32'hFFFF_FFFF);
      bus_write(5'h0C, 32'hFFFF_FFFF);
      bus_read(5'h10);
      check("wrap_hi_before", 64'(d1), 64'hFFFF_FFFF);
      bus_read(5'h10);
      check("wrap_hi_after", 64'(d1), 64'd0);
      bus_read(5'h0C);
      check("wrap_lo_1",  64'(d1), 64'd1);
      check("div4_lo_ff", 64'(d4), 64'hFFFF_FFFF);
      bus_read(5'h0C);
      check("wrap_lo_2",  64'(d1), 64'd2);
      bus_read(5'h0C);
      check("wrap_lo_3",  64'(d1), 64'd3);
      check("div4_lo_0",  64'(d4), 64'd0);

      // Mid-count reset with mtime=1000 and ext pending
      bus_write(5'h0C, 32'd1000);
      bus_write(5'h10, 32'd0);
      ext = 1'b1;
      @(negedge clk);
      ext = 1'b0;
      repeat (EXT_LAT + 1) @(negedge clk);
      check("pre_rst_meip", 64'(mip4[2]), 64'd1);
      bus_read(5'h0C);
      check("pre_rst_mtime", 64'(d4 >= 32'd1000 && d4 < 32'd1010), 64'd1);
      bus_read(5'h04);
      check("pre_rst_rdata", 64'(d4), 64'd10);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_rdata4", 64'(rdata4), 64'd0);
      check("mid_rst_req4",   64'(req4),   64'd0);
      check("mid_rst_cause4", 64'(cause4), 64'd0);
      check("mid_rst_mip4",   64'(mip4),   64'd0);
      check("mid_rst_rdata1", 64'(rdata1), 64'd0);
      check("mid_rst_mip1",   64'(mip1),   64'd0);
      rst = 1'b0;
      bus_read(5'h0C);
      check("post_rst_mtime4", 64'(d4), 64'd0);
      check("post_rst_mtime1", 64'(d1), 64'd0);
      bus_read(5'h04);
      check("post_rst_cmp4", 64'(d4), 64'hFFFF_FFFF);
      bus_read(5'h00);
      check("post_rst_msip", 64'(d4), 64'd0);
      check("post_rst_req1", 64'(req1), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Machine-level interrupt source for the 5-stage core, CLINT-style.
- Owns the software interrupt bit (msip), the 64-bit timer (mtime/mtimecmp) and the external interrupt pending latch.
- Presents one prioritised request plus an mcause-encoded cause to the trap decision logic.
- Retires the external pending bit when the pipeline acknowledges the trap.

Parameters:
- TICK_DIV, 1: core clocks per mtime increment; legal range 1..65535.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp, chosen so no timer interrupt fires out of reset.

Ports:
- clk  in  1  core clock; the block uses a single clock.
- rst  in  1  synchronous, active-high reset.
- bus_sel  in  1  register access strobe, one cycle per access.
- bus_we  in  1  write enable, qualified by bus_sel.
- bus_addr  in  5  byte offset; bits [4:2] select the word.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, registered.
- ext_irq  in  1  external interrupt line, level.
- mie_msie  in  1  software interrupt enable, from the CSR file.
- mie_mtie  in  1  timer interrupt enable, from the CSR file.
- mie_meie  in  1  external interrupt enable, from the CSR file.
- trap_ack  in  1  interrupt trap taken this cycle; pulse.
- interrupt_req  out  1  enabled interrupt pending.
- interrupt_cause  out  32  mcause value of the winning source.
- mip_bits  out  3  {MEIP, MTIP, MSIP} raw pending, for the mip CSR.

Behaviour:
- Reset values: bus_rdata=0, interrupt_req=0, interrupt_cause=0, mip_bits=0, msip=0, mtime=0, mtimecmp=MTIMECMP_RST, ext_pend=0, prescaler=0.
- Register map, word index bus_addr[4:2]:
  - 0: msip; bit0 R/W, other bits read as 0.
  - 1: mtimecmp[31:0].
  - 2: mtimecmp[63:32].
  - 3: mtime[31:0].
  - 4: mtime[63:32].
  - 5..7: reads return 0, writes are ignored.
  - bus_addr[1:0] is ignored.
- Read: bus_rdata updates on the cycle after bus_sel && !bus_we and holds until the next read.
- Write: takes effect at the clock edge where bus_sel && bus_we.
- Prescaler: counts 0..TICK_DIV-1. mtime increments by 1 on the edge where the prescaler equals TICK_DIV-1. The 64-bit counter wraps from all-ones to 0.
- Write to mtime lo or hi in a tick cycle: the written half takes bus_wdata; the other half keeps its old value (no increment, no carry). The prescaler is reset to 0 on any mtime write.
- MTIP: registered, unsigned mtime >= mtimecmp, using register values from the previous cycle. One cycle of latency after the compare becomes true.
- MSIP = msip register bit.
- MEIP = ext_pend.
  - ext_pend sets on a rising edge of the (synchronised) ext_irq, using a registered previous value.
  - ext_pend clears when trap_ack is asserted and the current cause is external.
  - Set and clear in the same cycle: set wins.
- Priority: external > software > timer, each gated by its mie bit.
  - interrupt_cause: 32'h8000000B for external, 32'h80000003 for software, 32'h80000007 for timer.
  - interrupt_cause holds its last value when no source is enabled.
- interrupt_req and interrupt_cause are combinational from registered state, with no extra latency.
- trap_ack has no effect on MSIP or MTIP. Software clears those by writing msip=0 or raising mtimecmp.
- mip_bits reports raw pending regardless of enables.

Optional Feature:
- Macro INTR_EXT_SYNC_EN.
- Defined: ext_irq passes through a two-flop synchroniser (reset to 0) before edge detection, adding 2 cycles of latency.
- Undefined: ext_irq is treated as already synchronous and edge-detected directly.

Decomposition:
- Shared package intr_pkg holds:
  - cause constants CAUSE_MSI, CAUSE_MTI, CAUSE_MEI;
  - word-index constants REG_MSIP, REG_MTIMECMP_LO/HI, REG_MTIME_LO/HI;
  - the MIP bit positions.
- One sub-module, intr_mtimer: prescaler, mtime, mtimecmp, write ports and the registered compare.
- Register decode and priority logic stay in the top module.

Test Plan:
- Reset, then read words 1 and 2 -> 32'hFFFFFFFF each. interrupt_req=0 for 100 cycles with all enables set.
- TICK_DIV=4; write mtimecmp lo=10, hi=0, then mtime lo=0; set mie_mtie=1.
  - Required: MTIP asserts exactly 41 cycles after the mtime write (40 cycles of counting plus 1 compare cycle).
  - Required: interrupt_cause=32'h80000007.
- Write msip=1 with mie_msie=1 -> interrupt_req on the next cycle with cause 32'h80000003. Write msip=0 -> req drops the next cycle.
- Timer and software pending, then ext_irq rises with all enables set.
  - Required: cause becomes 32'h8000000B.
  - Pulse trap_ack: ext_pend clears and cause returns to 32'h80000003.
- Write mtime hi=32'hFFFFFFFF, lo=32'hFFFFFFFF with TICK_DIV=1 -> the following reads show wrap to 0 and an increment from there.
- Assert rst mid-count, with mtime=1000 and ext_pend=1 -> next cycle all state is at reset values and interrupt_req=0.
